pwm_duty_conditioner: RTL and testbench
=======================================

Name: pwm_duty_conditioner

Overview:
- Upstream stage of the PWM generator. Conditions the raw 4-bit slide-switch input into a glitch-free duty code.
- Conditioning steps: two-flop synchronizer, whole-vector debounce, then a duty register that changes only on PWM period boundaries.
- The register slews one step per period toward the debounced target, so brightness never jumps mid-pulse or by more than one code per period.
- Output duty[3:0] feeds the PWM compare-value build, which places it in bits [18:15] of the 20-bit compare word.

Parameters:
- SW_W, 4, switch/duty code width
- DB_CYCLES, 50000, consecutive cycles a new synchronized value must hold before it is accepted (>=2)
- CNT_W, $clog2(DB_CYCLES), debounce counter width (derived)

Ports:
- clk  input  1  system clock, all logic rising-edge
- rst  input  1  synchronous reset, active-high
- sw  input  SW_W  raw asynchronous switch levels
- period_start  input  1  one-cycle pulse from the PWM counter on its wrap to 0
- duty  output  SW_W  registered duty code for the PWM comparator
- target  output  SW_W  debounced switch value
- settled  output  1  high when duty == target and no ramp is pending

Behaviour:
- One clock domain; synchronous active-high reset on clk.
- Reset values:
  - sync flops, target, duty, debounce counter: 0
  - FSM: IDLE
  - settled: 1
- Synchronizer:
  - sw passes through 2 flops to give sw_s.
  - Debounce logic sees sw_s only; no logic uses sw directly.
- Debounce, with a single counter for the whole vector:
  - sw_s == target: counter clears to 0.
  - sw_s != target and counter < DB_CYCLES-1: counter increments.
  - sw_s != target and counter == DB_CYCLES-1: target <= sw_s and counter clears.
  - A value change during counting (a different mismatch value) does not restart the count. The value accepted is whatever sw_s holds at acceptance.
  - Latency from a stable sw change to target update: exactly DB_CYCLES+2 clk edges.
  - Bounce shorter than DB_CYCLES cycles is rejected: the counter clears on the first matching cycle.
- Duty FSM, states IDLE / RAMP_UP / RAMP_DOWN, evaluated every cycle:
  - IDLE: if target > duty go to RAMP_UP; if target < duty go to RAMP_DOWN.
  - RAMP_UP: on period_start, duty <= duty+1. Go to IDLE when the updated duty == target.
  - RAMP_DOWN: on period_start, duty <= duty-1. Go to IDLE when the updated duty == target.
  - If target reverses direction mid-ramp, the FSM switches RAMP_UP <-> RAMP_DOWN on the next cycle without changing duty. If target becomes equal to duty, it goes to IDLE.
  - duty never wraps; it saturates at target, which lies in 0..2^SW_W-1.
  - duty changes only in the cycle after a period_start; without period_start, duty holds indefinitely.
- Simultaneous events:
  - A target update coinciding with period_start: the step uses the old target direction. The new target is seen from the next cycle.
- settled = (state == IDLE) && (duty == target), registered.
- Reset mid-ramp: duty returns to 0 immediately, with no ramp-down.

Optional Feature:
- SW_SLEW_EN defined: slew-limited behaviour as above, one code step per period_start.
- SW_SLEW_EN undefined:
  - The FSM is removed.
  - On period_start, duty <= target in one step.
  - settled = (duty == target).
  - Period alignment is still enforced.

Decomposition:
- Package pwm_pkg holds:
  - SW_W
  - typedef duty_t (logic [SW_W-1:0])
  - the enum duty_state_t {IDLE, RAMP_UP, RAMP_DOWN}
  - the PWM counter width CBITS = 20, so the comparator and this block share widths.
- Sub-module sw_debounce:
  - Contains the synchronizer and debounce counter, parameterized by SW_W and DB_CYCLES.
  - Output: target.
  - The top module contains the duty FSM only.

Test Plan (DB_CYCLES=8 for simulation, period_start every 16 cycles):
- Reset: assert rst for 3 cycles with sw=4'hF -> duty=0, target=0, settled=1. Target becomes F exactly 10 edges after rst deasserts.
- Bounce: toggle sw 0->5->0 with the 5 held only 6 cycles -> target stays 0 and the counter returns to 0.
- Slew up (SW_SLEW_EN): sw=0->3 stable -> after target=3, duty steps 1,2,3 on three successive period_starts; settled rises the cycle after duty=3.
- Reversal: target 0->9, then 9->2 while duty=4 -> duty goes 4,3,2 on following period_starts and never exceeds 4.
- No period_start: target=7, period_start held low 200 cycles -> duty unchanged, settled=0.
- Without SW_SLEW_EN: target=0->C -> duty=C on the first period_start after the target update, then settled=1.

Source files
------------

// File: rtl/pwm_pkg.sv
// Shared widths and types for the PWM datapath: switch/duty code width, PWM counter
// width and the duty-ramp state encoding.
package pwm_pkg;

  localparam int unsigned SW_W  = 4;
  localparam int unsigned CBITS = 20;

  typedef logic [SW_W-1:0] duty_t;

  typedef enum logic [1:0] {
    StIdle,
    StRampUp,
    StRampDown
  } duty_state_t;

endpackage

// File: rtl/sw_debounce.sv
// Two-flop synchronizer plus whole-vector debounce for the slide switches.
// A new synchronized value is accepted after DB_CYCLES consecutive mismatching cycles.
module sw_debounce #(
  parameter int unsigned SW_W      = 4,
  parameter int unsigned DB_CYCLES = 50000
) (
  input  logic            clk_i,
  input  logic            rst_i,
  input  logic [SW_W-1:0] sw_i,
  output logic [SW_W-1:0] target_o
);

  localparam int unsigned     CNT_W  = $clog2(DB_CYCLES);
  localparam logic [CNT_W-1:0] CntMax = CNT_W'(DB_CYCLES - 1);

  logic [SW_W-1:0]  sync1_q, sw_s_q;
  logic [SW_W-1:0]  target_q, target_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;

  // The count is shared by all bits: a mismatch that changes value mid-count keeps counting
  // and the value present at acceptance wins.
  always_comb begin
    cnt_d    = cnt_q;
    target_d = target_q;
    if (sw_s_q == target_q) begin
      cnt_d = '0;
    end else if (cnt_q == CntMax) begin
      target_d = sw_s_q;
      cnt_d    = '0;
    end else begin
      cnt_d = cnt_q + CNT_W'(1);
    end
  end

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      sync1_q  <= '0;
      sw_s_q   <= '0;
      target_q <= '0;
      cnt_q    <= '0;
    end else begin
      sync1_q  <= sw_i;
      sw_s_q   <= sync1_q;
      target_q <= target_d;
      cnt_q    <= cnt_d;
    end
  end

  assign target_o = target_q;

endmodule

// File: rtl/pwm_duty_conditioner.sv
// Conditions raw switches into a duty code that only moves on PWM period boundaries.
// Define SW_SLEW_EN to limit duty to one code step per period; otherwise it jumps to target.
module pwm_duty_conditioner
  import pwm_pkg::*;
#(
  parameter int unsigned DB_CYCLES = 50000
) (
  input  logic            clk_i,
  input  logic            rst_i,
  input  logic [SW_W-1:0] sw_i,
  input  logic            period_start_i,
  output logic [SW_W-1:0] duty_o,
  output logic [SW_W-1:0] target_o,
  output logic            settled_o
);

  duty_t duty_q, duty_d;
  logic  settled_q, settled_d;

  sw_debounce #(
    .SW_W     (SW_W),
    .DB_CYCLES(DB_CYCLES)
  ) u_debounce (
    .clk_i   (clk_i),
    .rst_i   (rst_i),
    .sw_i    (sw_i),
    .target_o(target_o)
  );

`ifdef SW_SLEW_EN
  duty_state_t state_q, state_d;

  // A target reversal or match only redirects the state; duty moves solely on period_start.
  always_comb begin
    state_d = state_q;
    duty_d  = duty_q;
    unique case (state_q)
      StIdle: begin
        if (target_o > duty_q) begin
          state_d = StRampUp;
        end else if (target_o < duty_q) begin
          state_d = StRampDown;
        end
      end
      StRampUp: begin
        if (target_o < duty_q) begin
          state_d = StRampDown;
        end else if (target_o == duty_q) begin
          state_d = StIdle;
        end else if (period_start_i) begin
          duty_d = duty_q + 1'b1;
          if (duty_d == target_o) begin
            state_d = StIdle;
          end
        end
      end
      StRampDown: begin
        if (target_o > duty_q) begin
          state_d = StRampUp;
        end else if (target_o == duty_q) begin
          state_d = StIdle;
        end else if (period_start_i) begin
          duty_d = duty_q - 1'b1;
          if (duty_d == target_o) begin
            state_d = StIdle;
          end
        end
      end
      default: state_d = StIdle;
    endcase
    settled_d = (state_q == StIdle) && (duty_q == target_o);
  end

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      state_q <= StIdle;
    end else begin
      state_q <= state_d;
    end
  end
`else
  always_comb begin
    duty_d = duty_q;
    if (period_start_i) begin
      duty_d = target_o;
    end
    settled_d = (duty_q == target_o);
  end
`endif

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      duty_q    <= '0;
      settled_q <= 1'b1;
    end else begin
      duty_q    <= duty_d;
      settled_q <= settled_d;
    end
  end

  assign duty_o    = duty_q;
  assign settled_o = settled_q;

endmodule

// File: tb/tb_pwm_duty_conditioner.sv
// Self-checking bench for pwm_duty_conditioner with DB_CYCLES=8 and a 16-cycle PWM period.
// Expected target updates and duty steps are queued as stimulus is applied, then popped.
module tb_pwm_duty_conditioner;

  localparam int unsigned DbCycles = 8;
  localparam int          TgtLat   = DbCycles + 2;
`ifdef SW_SLEW_EN
  localparam logic [3:0] StepVal = 4'h3;
`else
  localparam logic [3:0] StepVal = 4'hC;
`endif

  logic       clk = 1'b0;
  logic       rst;
  logic [3:0] sw;
  logic       period_start;
  logic [3:0] duty, target;
  logic       settled;

  int n_cmp = 0;
  int n_err = 0;
  int cyc   = 0;
  bit ps_auto = 1'b0;
  int ps_cnt  = 0;
  logic ps_prev;
  logic [3:0] tq[$];
  logic [3:0] dq[$];

  pwm_duty_conditioner #(
    .DB_CYCLES(DbCycles)
  ) dut (
    .clk_i         (clk),
    .rst_i         (rst),
    .sw_i          (sw),
    .period_start_i(period_start),
    .duty_o        (duty),
    .target_o      (target),
    .settled_o     (settled)
  );

  always #5 clk = ~clk;

  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation still running at %0t, required to finish earlier", $time);
    $fatal(1);
  end

  // Advance one edge; inputs are driven and outputs sampled 1 time unit after it.
  task automatic tick();
    ps_prev = period_start;
    @(posedge clk);
    #1;
    cyc++;
    if (ps_auto) begin
      ps_cnt       = (ps_cnt + 1) % 16;
      period_start = (ps_cnt == 0);
    end
  endtask

  task automatic do_reset(input logic [3:0] sw_val);
    rst          = 1'b1;
    ps_auto      = 1'b0;
    period_start = 1'b0;
    sw           = sw_val;
    repeat (3) tick();
    rst = 1'b0;
  endtask

  // Reference step sequence from one duty code to another.
  function automatic void push_steps(input logic [3:0] from, input logic [3:0] to);
`ifdef SW_SLEW_EN
    logic [3:0] d = from;
    while (d != to) begin
      d = (to > d) ? d + 4'd1 : d - 4'd1;
      dq.push_back(d);
    end
`else
    if (from != to) dq.push_back(to);
`endif
  endfunction

  task automatic wait_target(input string name, input int sw_cyc);
    logic [3:0] exp, prev;
    bit seen = 1'b0;
    int lat;
    exp  = tq.pop_front();
    prev = target;
    for (int i = 0; i < 4 * TgtLat && !seen; i++) begin
      tick();
      if (target !== prev) seen = 1'b1;
    end
    lat = cyc - sw_cyc;
    n_cmp++;
    if (!seen || target !== exp || lat != TgtLat) begin
      n_err++;
      $display("FAIL %s target: got %0h after %0d edges (seen=%0b), expected %0h after %0d",
               name, target, lat, seen, exp, TgtLat);
    end
  endtask

  // Every duty change must be the next queued value, one per period_start.
  task automatic drain_duty(input string name, input int budget);
    logic [3:0] prev, exp;
    int pulses = 0;
    ps_auto = 1'b1;
    ps_cnt  = 0;
    for (int i = 0; i < budget && dq.size() > 0; i++) begin
      prev = duty;
      tick();
      if (ps_prev === 1'b1) pulses++;
      if (duty !== prev) begin
        exp = dq.pop_front();
        n_cmp++;
        if (duty !== exp || ps_prev !== 1'b1 || pulses != 1) begin
          n_err++;
          $display("FAIL %s step: duty=%0h ps_prev=%0b pulses=%0d, expected %0h on 1 pulse",
                   name, duty, ps_prev, pulses, exp);
        end
        pulses = 0;
      end
    end
    n_cmp++;
    if (dq.size() != 0) begin
      n_err++;
      $display("FAIL %s drain: %0d steps pending, duty=%0h, expected 0 pending",
               name, dq.size(), duty);
      dq.delete();
    end
  endtask

  task automatic test_reset();
    int c0;
    rst          = 1'b1;
    period_start = 1'b0;
    sw           = 4'hF;
    repeat (3) tick();
    n_cmp++;
    if (duty !== 4'h0) begin
      n_err++; $display("FAIL reset duty: got %0h, expected 0", duty);
    end
    n_cmp++;
    if (target !== 4'h0) begin
      n_err++; $display("FAIL reset target: got %0h, expected 0", target);
    end
    n_cmp++;
    if (settled !== 1'b1) begin
      n_err++; $display("FAIL reset settled: got %0b, expected 1", settled);
    end
    rst = 1'b0;
    c0  = cyc;
    tq.push_back(4'hF);
    wait_target("reset_release", c0);
  endtask

  task automatic test_bounce();
    int mx = 0;
    int bad = 0;
    do_reset(4'h0);
    sw = 4'h5;
    repeat (6) tick();
    sw = 4'h0;
    for (int i = 0; i < 20; i++) begin
      tick();
      if (int'(dut.u_debounce.cnt_q) > mx) mx = int'(dut.u_debounce.cnt_q);
      if (target !== 4'h0) bad++;
    end
    n_cmp++;
    if (bad != 0) begin
      n_err++; $display("FAIL bounce target: %0d cycles non-zero (now %0h), expected 0", bad, target);
    end
    n_cmp++;
    if (mx != 6) begin
      n_err++; $display("FAIL bounce peak count: got %0d, expected 6", mx);
    end
    n_cmp++;
    if (dut.u_debounce.cnt_q !== 3'd0) begin
      n_err++; $display("FAIL bounce count clear: got %0d, expected 0", dut.u_debounce.cnt_q);
    end
  endtask

  task automatic test_step();
    int c0;
    do_reset(4'h0);
    sw = StepVal;
    c0 = cyc;
    tq.push_back(StepVal);
    wait_target("step", c0);
    push_steps(4'h0, StepVal);
    drain_duty("step", 200);
    n_cmp++;
    if (settled !== 1'b0) begin
      n_err++; $display("FAIL step settled early: got %0b, expected 0", settled);
    end
    tick();
    n_cmp++;
    if (settled !== 1'b1) begin
      n_err++; $display("FAIL step settled: got %0b, expected 1", settled);
    end
  endtask

  task automatic test_reversal();
    int c0;
    logic [3:0] mid;
    do_reset(4'h0);
    sw = 4'h9;
    c0 = cyc;
    tq.push_back(4'h9);
    wait_target("reversal_up", c0);
`ifdef SW_SLEW_EN
    mid = 4'h4;
`else
    mid = 4'h9;
`endif
    push_steps(4'h0, mid);
    drain_duty("reversal_up", 300);
    ps_auto      = 1'b0;
    period_start = 1'b0;
    sw           = 4'h2;
    c0           = cyc;
    tq.push_back(4'h2);
    wait_target("reversal_down", c0);
    n_cmp++;
    if (duty !== mid) begin
      n_err++; $display("FAIL reversal hold: duty=%0h, expected %0h", duty, mid);
    end
    push_steps(mid, 4'h2);
    drain_duty("reversal_down", 200);
  endtask

  task automatic test_no_period();
    int c0;
    int bad = 0;
    do_reset(4'h0);
    sw = 4'h7;
    c0 = cyc;
    tq.push_back(4'h7);
    wait_target("no_period", c0);
    for (int i = 0; i < 200; i++) begin
      tick();
      if (duty !== 4'h0 || settled !== 1'b0) bad++;
    end
    n_cmp++;
    if (bad != 0) begin
      n_err++;
      $display("FAIL no_period hold: %0d bad cycles, duty=%0h settled=%0b, expected 0/0",
               bad, duty, settled);
    end
    push_steps(4'h0, 4'h7);
    drain_duty("no_period_resume", 200);
  endtask

  // Target update and period_start on the same edge: the step uses the old target.
  task automatic test_coincide();
    int c0;
    do_reset(4'h0);
    sw = 4'h6;
    c0 = cyc;
    repeat (TgtLat - 1) tick();
    period_start = 1'b1;
    tick();
    period_start = 1'b0;
    n_cmp++;
    if (target !== 4'h6 || cyc - c0 != TgtLat) begin
      n_err++; $display("FAIL coincide target: got %0h, expected 6", target);
    end
    n_cmp++;
    if (duty !== 4'h0) begin
      n_err++; $display("FAIL coincide duty: got %0h, expected 0", duty);
    end
    push_steps(4'h0, 4'h6);
    drain_duty("coincide", 200);
  endtask

  task automatic test_reset_mid();
    int c0;
    bit moved = 1'b0;
    do_reset(4'h0);
    sw = 4'hF;
    c0 = cyc;
    tq.push_back(4'hF);
    wait_target("reset_mid", c0);
    ps_auto = 1'b1;
    ps_cnt  = 0;
    for (int i = 0; i < 40 && !moved; i++) begin
      tick();
      if (duty !== 4'h0) moved = 1'b1;
    end
    n_cmp++;
    if (!moved) begin
      n_err++; $display("FAIL reset_mid start: duty=%0h, expected non-zero", duty);
    end
    rst = 1'b1;
    tick();
    rst = 1'b0;
    ps_auto = 1'b0;
    n_cmp++;
    if (duty !== 4'h0 || target !== 4'h0 || settled !== 1'b1) begin
      n_err++;
      $display("FAIL reset_mid: duty=%0h target=%0h settled=%0b, expected 0/0/1",
               duty, target, settled);
    end
  endtask

  initial begin
    rst          = 1'b1;
    sw           = 4'h0;
    period_start = 1'b0;
    ps_prev      = 1'b0;
    test_reset();
    test_bounce();
    test_step();
    test_reversal();
    test_no_period();
    test_coincide();
    test_reset_mid();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
